// File: rtl/cpu_step_if.sv
// cpu_step_if
// Bundles the mode/debug inputs and the advance outputs of the CPU step
// controller so the controller and its driver share one port list.
//   slave  : controller side (takes i_* in, drives o_* out)
//   master : driver side (drives i_*, observes o_*)
// Signals:
//   i_mode       2     00 full speed, 01 divided, 10 single-step, 11 breakpoint
//   i_div_sel    5     divided mode period select (2^div_sel cycles)
//   i_button     1     raw push button, 1 = pressed
//   i_bp_en      1     breakpoint enable
//   i_bp_addr    PC_W  breakpoint PC
//   i_pc         PC_W  current fetch PC of the CPU
//   i_cnt_clr    1     synchronous clear of the advance counter
//   o_cpu_ce     1     one-cycle advance enable
//   o_halted     1     stopped at a breakpoint
//   o_btn_pulse  1     one-cycle pulse per accepted press
//   o_adv_count  CNT_W number of advances issued
interface cpu_step_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 32
);
    logic [1:0]       i_mode;
    logic [4:0]       i_div_sel;
    logic             i_button;
    logic             i_bp_en;
    logic [PC_W-1:0]  i_bp_addr;
    logic [PC_W-1:0]  i_pc;
    logic             i_cnt_clr;
    logic             o_cpu_ce;
    logic             o_halted;
    logic             o_btn_pulse;
    logic [CNT_W-1:0] o_adv_count;

    modport slave (
        input  i_mode, i_div_sel, i_button, i_bp_en, i_bp_addr, i_pc, i_cnt_clr,
        output o_cpu_ce, o_halted, o_btn_pulse, o_adv_count
    );

    modport master (
        output i_mode, i_div_sel, i_button, i_bp_en, i_bp_addr, i_pc, i_cnt_clr,
        input  o_cpu_ce, o_halted, o_btn_pulse, o_adv_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// cpu_step_controller
// Single-clock execution controller. Generates a registered clock-enable
// pulse (o_cpu_ce) that all CPU state qualifies its updates with, in one of
// four modes: full speed, power-of-two divided, debounced single-step, and
// run-to-breakpoint with step-past. Also counts issued advances.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous reset, active-low
//   bus      cpu_step_if.slave (mode/debug inputs, advance outputs)
module cpu_step_controller #(
    parameter int DIV_W     = 24,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16,
    parameter int PC_W      = 16,
    parameter int CNT_W     = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    cpu_step_if.slave   bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [1:0] MODE_FULL  = 2'b00;
    localparam logic [1:0] MODE_DIV   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BREAK = 2'b11;

    localparam logic [DB_W-1:0] DB_CNT_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [4:0]      DIV_SEL_MAX = 5'(DIV_W - 1);

    logic [1:0]       r_sync;
    logic             r_dbLevel;
    logic [DB_W-1:0]  r_dbCnt;
    logic             r_btnPulse;
    logic [DIV_W-1:0] r_div;
    logic [0:0]       r_state;
    logic             r_bpMask;
    logic             r_cpuCe;
    logic [CNT_W-1:0] r_advCount;

    logic             w_synced;
    logic             w_dbDiffer;
    logic             w_dbFlip;
    logic [4:0]       w_divSel;
    logic [DIV_W-1:0] w_divMask;
    logic             w_tick;
    logic             w_pcAtBp;
    logic             w_breakArmed;
    logic             w_hit;
    logic             w_adv;

    assign w_synced   = r_sync[1];
    assign w_dbDiffer = (w_synced != r_dbLevel);
    assign w_dbFlip   = w_dbDiffer && (r_dbCnt == DB_CNT_MAX);

    // Out-of-range selects clamp to the slowest period the divider can make.
    assign w_divSel  = (bus.i_div_sel > DIV_SEL_MAX) ? DIV_SEL_MAX : bus.i_div_sel;
    assign w_divMask = (DIV_W'(1) << w_divSel) - DIV_W'(1);
    assign w_tick    = ((r_div & w_divMask) == w_divMask);

    assign w_pcAtBp     = (bus.i_pc == bus.i_bp_addr);
    assign w_breakArmed = (bus.i_mode == MODE_BREAK) && bus.i_bp_en;
    // The mask suppresses a re-hit on the breakpoint we just stepped off.
    assign w_hit        = w_breakArmed && w_pcAtBp && !r_bpMask && (r_state == ST_RUN);

    always_comb begin
        w_adv = 1'b0;
        case (bus.i_mode)
            MODE_FULL:  w_adv = 1'b1;
            MODE_DIV:   w_adv = w_tick;
            MODE_STEP:  w_adv = r_btnPulse;
            MODE_BREAK: w_adv = (r_state == ST_RUN) ? !w_hit : (r_btnPulse && bus.i_bp_en);
            default:    w_adv = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.i_button};
        end
    end

    // Only a rising debounced edge produces a press pulse; release is silent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbLevel  <= 1'b0;
            r_dbCnt    <= '0;
            r_btnPulse <= 1'b0;
        end else begin
            r_btnPulse <= w_dbFlip && w_synced;
            if (!w_dbDiffer) begin
                r_dbCnt <= '0;
            end else if (w_dbFlip) begin
                r_dbCnt   <= '0;
                r_dbLevel <= w_synced;
            end else begin
                r_dbCnt <= r_dbCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Leaving HALT by a press sets the mask so the stepped instruction does
    // not immediately re-trigger; leaving by mode/enable change issues nothing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_bpMask <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hit) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!w_breakArmed || r_btnPulse) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase

            if ((r_state == ST_HALT) && w_breakArmed && r_btnPulse) begin
                r_bpMask <= 1'b1;
            end else if (!w_pcAtBp) begin
                r_bpMask <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpuCe    <= 1'b0;
            r_advCount <= '0;
        end else begin
            r_cpuCe <= w_adv;
            if (bus.i_cnt_clr) begin
                r_advCount <= '0;
            end else if (r_cpuCe) begin
                r_advCount <= r_advCount + 1'b1;
            end
        end
    end

    assign bus.o_cpu_ce    = r_cpuCe;
    assign bus.o_halted    = (r_state == ST_HALT);
    assign bus.o_btn_pulse = r_btnPulse;
    assign bus.o_adv_count = r_advCount;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller
// Self-checking bench for cpu_step_controller. Expected values are queued
// when stimulus is applied and compared when the DUT output is observed.
// Small parameters keep every mode observable in a few hundred cycles.
module tb_cpu_step_controller;

    localparam int DIV_W     = 6;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;
    localparam int PC_W      = 16;
    localparam int CNT_W     = 8;

    logic clk;
    logic rstN;
    logic pcFollow;

    int checks = 0;
    int errors = 0;

    string       expTag[$];
    logic [31:0] expVal[$];

    cpu_step_if #(.PC_W(PC_W), .CNT_W(CNT_W)) ifc ();

    cpu_step_controller #(
        .DIV_W(DIV_W), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W),
        .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] val);
        expTag.push_back(tag);
        expVal.push_back(val);
    endtask

    task automatic popCheck(input logic [31:0] observed);
        string       tag;
        logic [31:0] val;
        if (expTag.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'(expTag.size()), 32'd1);
        end else begin
            tag = expTag.pop_front();
            val = expVal.pop_front();
            checkOutput(tag, observed, val);
        end
    endtask

    // One clock; the CPU model advances its fetch PC on each advance it sees
    // and branches from 9 back to 3 to exercise breakpoint re-entry.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (pcFollow && ifc.o_cpu_ce) begin
            ifc.i_pc = (ifc.i_pc == 16'd9) ? 16'd3 : ifc.i_pc + 16'd1;
        end
    endtask

    task automatic runDivWindow(input logic [4:0] sel, input int period, input int samples);
        int pulses;
        int last;
        ifc.i_div_sel = sel;
        ifc.i_cnt_clr = 1'b1;
        pushExp("divPulses", 32'(samples / period));
        pushExp("divCount", 32'(samples / period));
        applyStimulus();
        ifc.i_cnt_clr = 1'b0;
        pulses = 0;
        last = -1;
        for (int i = 0; i < samples; i++) begin
            if (i > 0) applyStimulus();
            if (ifc.o_cpu_ce) begin
                if (last >= 0) checkOutput("divGap", 32'(i - last), 32'(period));
                last = i;
                pulses++;
            end
        end
        popCheck(32'(pulses));
        applyStimulus();
        popCheck(32'(ifc.o_adv_count));
    endtask

    initial begin
        int pulses;
        int ces;
        int pulseIdx;
        int ceIdx;
        int n;

        rstN = 1'b0;
        pcFollow = 1'b0;
        ifc.i_mode = 2'b00;
        ifc.i_div_sel = 5'd0;
        ifc.i_button = 1'b0;
        ifc.i_bp_en = 1'b0;
        ifc.i_bp_addr = 16'd5;
        ifc.i_pc = 16'd0;
        ifc.i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetCe", 32'(ifc.o_cpu_ce), 32'd0);
        checkOutput("resetHalted", 32'(ifc.o_halted), 32'd0);
        checkOutput("resetBtn", 32'(ifc.o_btn_pulse), 32'd0);
        checkOutput("resetCount", 32'(ifc.o_adv_count), 32'd0);

        // Full speed straight out of reset.
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            pushExp("fullCe", 32'd1);
            pushExp("fullCount", 32'(k - 1));
            pushExp("fullHalted", 32'd0);
        end
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            popCheck(32'(ifc.o_cpu_ce));
            popCheck(32'(ifc.o_adv_count));
            popCheck(32'(ifc.o_halted));
        end

        // Clear wins over a simultaneous advance, then wrap the counter.
        ifc.i_cnt_clr = 1'b1;
        pushExp("clrWithCe", 32'd0);
        applyStimulus();
        ifc.i_cnt_clr = 1'b0;
        popCheck(32'(ifc.o_adv_count));
        pushExp("wrapTop", 32'd255);
        repeat (255) applyStimulus();
        popCheck(32'(ifc.o_adv_count));
        pushExp("wrapZero", 32'd0);
        applyStimulus();
        popCheck(32'(ifc.o_adv_count));

        // Divided mode, in range and clamped select.
        ifc.i_mode = 2'b01;
        runDivWindow(5'd3, 8, 64);
        runDivWindow(5'd31, 32, 128);

        // Single-step with a bouncing press, then a release.
        ifc.i_mode = 2'b10;
        ifc.i_cnt_clr = 1'b1;
        applyStimulus();
        ifc.i_cnt_clr = 1'b0;
        pushExp("stepBtnPulses", 32'd1);
        pushExp("stepCePulses", 32'd1);
        pushExp("stepCeAfterPulse", 32'd1);
        pushExp("stepCount", 32'd1);
        pulses = 0; ces = 0; pulseIdx = -100; ceIdx = 0;
        for (int i = 0; i < 18; i++) begin
            ifc.i_button = (i < 4) ? ((i % 2) == 0) : 1'b1;
            applyStimulus();
            if (ifc.o_btn_pulse) begin pulses++; pulseIdx = i; end
            if (ifc.o_cpu_ce) begin ces++; ceIdx = i; end
        end
        popCheck(32'(pulses));
        popCheck(32'(ces));
        popCheck(32'(ceIdx - pulseIdx));
        popCheck(32'(ifc.o_adv_count));
        pushExp("releaseBtnPulses", 32'd0);
        pushExp("releaseCePulses", 32'd0);
        ifc.i_button = 1'b0;
        pulses = 0; ces = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (ifc.o_btn_pulse) pulses++;
            if (ifc.o_cpu_ce) ces++;
        end
        popCheck(32'(pulses));
        popCheck(32'(ces));

        // Run to breakpoint at 5.
        ifc.i_pc = 16'd0;
        ifc.i_bp_en = 1'b1;
        ifc.i_bp_addr = 16'd5;
        ifc.i_mode = 2'b11;
        pcFollow = 1'b1;
        pushExp("haltSeen", 32'd1);
        pushExp("haltPc", 32'd5);
        pushExp("haltCe", 32'd0);
        n = 0;
        while (n < 40 && !ifc.o_halted) begin applyStimulus(); n++; end
        popCheck(32'(ifc.o_halted));
        popCheck(32'(ifc.i_pc));
        popCheck(32'(ifc.o_cpu_ce));
        for (int i = 0; i < 5; i++) begin
            pushExp("holdCe", 32'd0);
            pushExp("holdPc", 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            popCheck(32'(ifc.o_cpu_ce));
            popCheck(32'(ifc.i_pc));
        end

        // Press to step past the breakpoint.
        ifc.i_button = 1'b1;
        pushExp("resumeCe", 32'd1);
        pushExp("resumePc", 32'd6);
        pushExp("resumeHalted", 32'd0);
        ces = 0; n = 0;
        while (n < 20 && ifc.o_halted) begin
            applyStimulus();
            if (ifc.o_cpu_ce) ces++;
            n++;
        end
        popCheck(32'(ces));
        popCheck(32'(ifc.i_pc));
        popCheck(32'(ifc.o_halted));

        // Loop back through 5 and halt again.
        ifc.i_button = 1'b0;
        pushExp("reHalt", 32'd1);
        pushExp("reHaltPc", 32'd5);
        n = 0;
        while (n < 40 && !ifc.o_halted) begin applyStimulus(); n++; end
        popCheck(32'(ifc.o_halted));
        popCheck(32'(ifc.i_pc));

        // Switching to full speed releases the halt with no extra pulse.
        ifc.i_mode = 2'b00;
        pcFollow = 1'b0;
        pushExp("exitHalted", 32'd0);
        pushExp("exitCe", 32'd1);
        pushExp("exitRunCe", 32'd4);
        applyStimulus();
        popCheck(32'(ifc.o_halted));
        popCheck(32'(ifc.o_cpu_ce));
        ces = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            if (ifc.o_cpu_ce) ces++;
        end
        popCheck(32'(ces));

        // Reset while halted and mid-debounce.
        ifc.i_pc = 16'd2;
        ifc.i_mode = 2'b11;
        pcFollow = 1'b1;
        pushExp("halt3", 32'd1);
        n = 0;
        while (n < 20 && !ifc.o_halted) begin applyStimulus(); n++; end
        popCheck(32'(ifc.o_halted));
        ifc.i_button = 1'b1;
        repeat (3) applyStimulus();
        pushExp("preResetCountNonZero", 32'd1);
        popCheck(32'(ifc.o_adv_count != 0));
        pushExp("rstCe", 32'd0);
        pushExp("rstHalted", 32'd0);
        pushExp("rstBtn", 32'd0);
        pushExp("rstCount", 32'd0);
        #2;
        rstN = 1'b0;
        #1;
        popCheck(32'(ifc.o_cpu_ce));
        popCheck(32'(ifc.o_halted));
        popCheck(32'(ifc.o_btn_pulse));
        popCheck(32'(ifc.o_adv_count));

        checkOutput("scoreboardDrained", 32'(expTag.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
